// File: rtl/dev_timer_if.sv
// Bus bundle between the CPU memory stage and the dev_timer responder.
// master: CPU side (drives the access); slave: timer side (returns data and irq).
interface dev_timer_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             en;     // device select, access valid this cycle
  logic             we;     // write strobe, qualified by en
  logic [1:0]       addr;   // word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;  // combinational from addr
  logic             irq;

  modport master (
    output en, we, addr, wdata,
    input  rdata, irq
  );

  modport slave (
    input  en, we, addr, wdata,
    output rdata, irq
  );
endinterface

// File: rtl/dev_timer.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and an expiry irq.
// CTRL: [0] EN, [2:1] MODE (01 auto-reload, anything else one-shot), [3] IM (irq mask).
// Optional feature: define TIMER_PRESCALE_EN to step COUNT once every PRESCALE cycles.
module dev_timer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PRESCALE = 4
) (
  input logic        clk_i,
  input logic        rst_ni,
  dev_timer_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  // A zero prescale would never produce a step.
  if (PRESCALE == 0) begin : g_prescale_chk
    $error("dev_timer: PRESCALE must be >= 1");
  end

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wr_ctrl, wr_preset;
  logic             auto_reload;
  logic             step;

  assign wr_ctrl     = bus_io.en & bus_io.we & (bus_io.addr == 2'd0);
  assign wr_preset   = bus_io.en & bus_io.we & (bus_io.addr == 2'd1);
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PsW-1:0] presc_q, presc_d;

  assign step = (presc_q == PsW'(PRESCALE - 1));

  // Prescaler runs only while counting; any other state restarts it from 0.
  always_comb begin
    presc_d = '0;
    if (state_q == StCnt && !step) begin
      presc_d = presc_q + PsW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign step = 1'b1;
`endif

  // Next-state logic: FSM first, then a CTRL write overrides whatever the FSM chose.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    count_d  = count_q;
    preset_d = preset_q;

    unique case (state_q)
      StIdle: begin
        if (ctrl_q[0]) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!ctrl_q[0]) begin
          state_d = StIdle;
        end else if (step) begin
          if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            state_d = StInt;
            // One-shot disarms itself on expiry.
            if (!auto_reload) ctrl_d[0] = 1'b0;
          end
        end
      end
      StInt: begin
        if (auto_reload) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase

    if (wr_ctrl) begin
      ctrl_d  = bus_io.wdata[3:0];
      state_d = bus_io.wdata[0] ? StLoad : StIdle;
      count_d = count_q;
    end

    // PRESET never touches COUNT directly; it is picked up at the next LOAD.
    if (wr_preset) preset_d = bus_io.wdata;
  end

  // State and register file.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  // Zero-latency read mux, independent of en.
  always_comb begin
    bus_io.rdata = '0;
    unique case (bus_io.addr)
      2'd0:    bus_io.rdata = {{(WIDTH - 4){1'b0}}, ctrl_q};
      2'd1:    bus_io.rdata = preset_q;
      2'd2:    bus_io.rdata = count_q;
      default: bus_io.rdata = '0;
    endcase
  end

  assign bus_io.irq = (state_q == StInt) & ctrl_q[3];

endmodule

// File: tb/tb_dev_timer.sv
// Self-checking bench for dev_timer: directed scenarios plus random traffic, all
// checked against a timeline model (state/count derived from the cycle of the last LOAD).
module tb_dev_timer;
  localparam int unsigned W = 32;
`ifdef TIMER_PRESCALE_EN
  localparam int unsigned S = 4;
`else
  localparam int unsigned S = 1;
`endif

  logic clk;
  logic rst_n;

  dev_timer_if #(.WIDTH(W)) bus ();

  dev_timer #(
    .WIDTH   (W),
    .PRESCALE(4)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Model: while running, everything follows from k = cycles since the LOAD cycle.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_frozen;  // COUNT value outside a run (and during the LOAD cycle)
  logic [31:0] m_p;       // PRESET value latched by the current LOAD
  bit          m_run;
  longint      m_load_at;
  longint      cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    m_ctrl   = '0;
    m_preset = '0;
    m_frozen = '0;
    m_p      = '0;
    m_run    = 1'b0;
    m_load_at = 0;
  endfunction

  // st: 0 idle, 1 load, 2 counting, 3 expired.
  function automatic void m_now(output int st, output logic [31:0] cnt);
    longint k, kint;
    if (!m_run) begin
      st  = 0;
      cnt = m_frozen;
    end else begin
      k    = cyc - m_load_at;
      kint = 1 + (longint'(m_p) + 1) * longint'(S);
      if (k == 0) begin
        st  = 1;
        cnt = m_frozen;
      end else if (k < kint) begin
        st  = 2;
        cnt = m_p - 32'((k - 1) / longint'(S));
      end else begin
        st  = 3;
        cnt = '0;
      end
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a, input logic [31:0] cnt);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return cnt;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one clock edge given the inputs presented at it.
  function automatic void m_update(input logic e, input logic w, input logic [1:0] a,
                                   input logic [31:0] d);
    int          st;
    logic [31:0] cnt;
    longint      k, kint;
    m_now(st, cnt);
    if (e && w && a == 2'd0) begin
      m_ctrl    = d[3:0];
      m_frozen  = cnt;
      m_run     = d[0];
      m_load_at = cyc + 1;
    end else if (m_run) begin
      k = cyc - m_load_at;
      if (k == 0) m_p = m_preset;
      kint = 1 + (longint'(m_p) + 1) * longint'(S);
      if (k == kint - 1 && m_ctrl[2:1] != 2'b01) m_ctrl[0] = 1'b0;
      if (k == kint && m_ctrl[2:1] == 2'b01) begin
        m_load_at = cyc + 1;
        m_frozen  = cnt;
      end
    end
    if (e && w && a == 2'd1) m_preset = d;
    cyc++;
  endfunction

  // One bus cycle; entered and left 1ns after a rising edge.
  task automatic bus_cycle(input logic e, input logic w, input logic [1:0] a,
                           input logic [31:0] d);
    int          st;
    logic [31:0] cnt;
    bus.en    = e;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    #1;
    m_now(st, cnt);
    check_eq("rdata", bus.rdata, m_read(a, cnt));
    check_eq("irq", 32'(bus.irq), 32'((st == 3) && m_ctrl[3]));
    @(posedge clk);
    m_update(e, w, a, d);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic rd_n(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic apply_reset();
    bus.en = 1'b0;
    bus.we = 1'b0;
    #1;
    rst_n = 1'b0;
    m_reset();
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a);
      #1;
      check_eq("rst_rdata", bus.rdata, 32'd0);
    end
    check_eq("rst_irq", 32'(bus.irq), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    m_update(1'b0, 1'b0, 2'd0, 32'd0);
    #1;
  endtask

  longint irq_cyc[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 2'd0;
    bus.wdata = '0;
    m_reset();
    @(posedge clk);
    #1;
    apply_reset();
    rd_n(2'd2, 3);

    // One-shot, P=3, IM=1: COUNT steps 3..0, then irq held with EN cleared.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    rd_n(2'd2, 1);
    for (int j = 0; j < 4 * int'(S); j++) begin
      check_eq("oneshot_count", bus.rdata, 32'(3 - j / int'(S)));
      rd_n(2'd2, 1);
    end
    check_eq("oneshot_irq", 32'(bus.irq), 32'd1);
    rd_n(2'd0, 4);
    wr(2'd0, 32'h0);
    check_eq("oneshot_irq_clear", 32'(bus.irq), 32'd0);
    rd_n(2'd0, 2);

    // Auto-reload, P=2: fixed irq period, then PRESET change picked up at next LOAD.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    irq_cyc.delete();
    for (int i = 0; i < 6 * (3 * int'(S) + 2); i++) begin
      rd_n(2'(i % 3), 1);
      if (bus.irq) irq_cyc.push_back(cyc);
    end
    check_eq("auto_pulses", 32'(irq_cyc.size() >= 3), 32'd1);
    for (int i = 1; i < irq_cyc.size(); i++) begin
      check_eq("auto_period", 32'(irq_cyc[i] - irq_cyc[i-1]), 32'(3 * S + 2));
    end
    wr(2'd1, 32'd4);
    rd_n(2'd2, 40);
    wr(2'd0, 32'h0);

    // Pause mid-count, then resume with a fresh reload.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    rd_n(2'd2, 1 + 3 * int'(S));
    wr(2'd0, 32'h0);
    rd_n(2'd2, 20);
    wr(2'd0, 32'h1);
    rd_n(2'd2, 15);
    wr(2'd0, 32'h0);

    // Masked expiry with PRESET=0, COUNT write ignored, reserved offset reads 0.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    rd_n(2'd2, 8);
    wr(2'd2, 32'h55);
    rd_n(2'd2, 2);
    wr(2'd3, 32'hFFFF_FFFF);
    rd_n(2'd3, 2);

    // Reset while counting.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    rd_n(2'd2, 4);
    apply_reset();
    rd_n(2'd0, 4);

    // Random traffic: sparse writes, reads everywhere else.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        d = (a == 2'd1) ? 32'($urandom_range(0, 7)) : $urandom;
        wr(a, d);
      end else begin
        bus_cycle(1'($urandom_range(0, 1)), 1'b0, a, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
